// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing generator: pixel divider, h/v counters, registered sync/visible/coordinate outputs
module vga_sync_gen #(
   parameter int   CLK_DIV   = 4,
   parameter int   H_VISIBLE = 640,
   parameter int   H_FRONT   = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BACK    = 48,
   parameter int   V_VISIBLE = 480,
   parameter int   V_FRONT   = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BACK    = 33,
   parameter logic SYNC_POL  = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       hsync,
   output logic       vsync,
   output logic       h_visable,
   output logic       v_visable,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       pix_tick,
   output logic       frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Counter wrap points; the reset position is the last (blanked) slot of the frame
   localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);

   // Decode boundaries kept one bit wider so an end bound of 1024 does not alias to 0
   localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
   localparam logic [10:0] HS_BEG    = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
   localparam logic [10:0] VS_BEG    = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [3:0] div_cnt;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;

   logic       pix_en;
   logic [3:0] div_nxt;
   logic [9:0] h_nxt;
   logic [9:0] v_nxt;

   logic       h_vis_nxt;
   logic       v_vis_nxt;
   logic       hs_act_nxt;
   logic       vs_act_nxt;
   logic       origin_nxt;

   // Next-state counters: the divider always runs, the raster advances only on the last divider slot
   always_comb begin
      pix_en  = (div_cnt == DIV_LAST);
      div_nxt = pix_en ? 4'd0 : div_cnt + 4'd1;
      h_nxt   = h_cnt;
      v_nxt   = v_cnt;
      if (pix_en) begin
         if (h_cnt == H_LAST) begin
            h_nxt = 10'd0;
            v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
         end else begin
            h_nxt = h_cnt + 10'd1;
         end
      end
   end

   // Decode the next position so the registered outputs line up with the counters
   always_comb begin
      h_vis_nxt  = ({1'b0, h_nxt} < H_VIS_END);
      v_vis_nxt  = ({1'b0, v_nxt} < V_VIS_END);
      hs_act_nxt = ({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END);
      vs_act_nxt = ({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END);
      origin_nxt = (h_nxt == 10'd0) && (v_nxt == 10'd0);
   end

   // Divider and raster position state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt <= 4'd0;
         h_cnt   <= H_LAST;
         v_cnt   <= V_LAST;
      end else begin
         div_cnt <= div_nxt;
         h_cnt   <= h_nxt;
         v_cnt   <= v_nxt;
      end
   end

   // Registered timing outputs, updated on the same edge as the counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         h_visable   <= 1'b0;
         v_visable   <= 1'b0;
         pixel_x     <= 10'd0;
         pixel_y     <= 10'd0;
         pix_tick    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= hs_act_nxt ? SYNC_POL : ~SYNC_POL;
         vsync       <= vs_act_nxt ? SYNC_POL : ~SYNC_POL;
         h_visable   <= h_vis_nxt;
         v_visable   <= v_vis_nxt;
         pixel_x     <= h_vis_nxt ? h_nxt : 10'd0;
         pixel_y     <= v_vis_nxt ? v_nxt : 10'd0;
         pix_tick    <= pix_en;
         frame_start <= pix_en && origin_nxt;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen over small, CLK_DIV=1 and default rasters
module tb_vga_sync_gen;

   logic clk;
   logic rst_n;

   logic       a_hs, a_vs, a_hv, a_vv, a_tk, a_fs;
   logic [9:0] a_px, a_py;
   logic       b_hs, b_vs, b_hv, b_vv, b_tk, b_fs;
   logic [9:0] b_px, b_py;
   logic       c_hs, c_vs, c_hv, c_vv, c_tk, c_fs;
   logic [9:0] c_px, c_py;

   int total = 0;
   int bad   = 0;
   int t     = 0;

   logic [25:0] q_a[$];
   logic [25:0] q_b[$];
   logic [25:0] q_c[$];

   vga_sync_gen #(
      .CLK_DIV(4), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b0)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .hsync(a_hs), .vsync(a_vs), .h_visable(a_hv), .v_visable(a_vv),
      .pixel_x(a_px), .pixel_y(a_py), .pix_tick(a_tk), .frame_start(a_fs)
   );

   vga_sync_gen #(
      .CLK_DIV(1), .H_VISIBLE(10), .H_FRONT(1), .H_SYNC(4), .H_BACK(2),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .SYNC_POL(1'b1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .hsync(b_hs), .vsync(b_vs), .h_visable(b_hv), .v_visable(b_vv),
      .pixel_x(b_px), .pixel_y(b_py), .pix_tick(b_tk), .frame_start(b_fs)
   );

   vga_sync_gen dut_c (
      .clk(clk), .rst_n(rst_n), .hsync(c_hs), .vsync(c_vs), .h_visable(c_hv), .v_visable(c_vv),
      .pixel_x(c_px), .pixel_y(c_py), .pix_tick(c_tk), .frame_start(c_fs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: position is the (k-1)-th slot of the frame after k advances; k = edges/div since reset
   function automatic logic [25:0] model(input int tt, input int div,
                                         input int hv, input int hf, input int hs, input int hb,
                                         input int vv, input int vf, input int vs, input int vb,
                                         input logic pol);
      int k, ht, vt, l, h, v;
      logic hsy, vsy, hvis, vvis, tick, fs;
      logic [9:0] px, py;
      k = tt / div;
      if (k == 0) return {~pol, ~pol, 2'b00, 20'd0, 2'b00};
      ht   = hv + hf + hs + hb;
      vt   = vv + vf + vs + vb;
      l    = (k - 1) % (ht * vt);
      h    = l % ht;
      v    = l / ht;
      hsy  = (h >= hv + hf && h < hv + hf + hs) ? pol : ~pol;
      vsy  = (v >= vv + vf && v < vv + vf + vs) ? pol : ~pol;
      hvis = (h < hv);
      vvis = (v < vv);
      px   = hvis ? 10'(h) : 10'd0;
      py   = vvis ? 10'(v) : 10'd0;
      tick = ((tt % div) == 0);
      fs   = tick && (l == 0);
      return {hsy, vsy, hvis, vvis, px, py, tick, fs};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   // One clock: drive rst_n, queue the expectation, then compare after the edge
   task automatic step(input logic r);
      logic [25:0] e;
      rst_n = r;
      t = r ? t + 1 : 0;
      q_a.push_back(model(t, 4, 16, 2, 3, 3, 6, 2, 2, 2, 1'b0));
      q_b.push_back(model(t, 1, 10, 1, 4, 2, 4, 1, 1, 2, 1'b1));
      q_c.push_back(model(t, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      @(posedge clk);
      #1;
      e = q_a.pop_front();
      chk("dut_a", {6'd0, a_hs, a_vs, a_hv, a_vv, a_px, a_py, a_tk, a_fs}, {6'd0, e});
      e = q_b.pop_front();
      chk("dut_b", {6'd0, b_hs, b_vs, b_hv, b_vv, b_px, b_py, b_tk, b_fs}, {6'd0, e});
      e = q_c.pop_front();
      chk("dut_c", {6'd0, c_hs, c_vs, c_hv, c_vv, c_px, c_py, c_tk, c_fs}, {6'd0, e});
   endtask

   initial begin
      rst_n = 1'b0;

      repeat (5) step(1'b0);
      chk("rst_hsync", {31'd0, c_hs}, 32'd1);
      chk("rst_vsync", {31'd0, c_vs}, 32'd1);
      chk("rst_vis", {30'd0, c_hv, c_vv}, 32'd0);
      chk("rst_pix", {12'd0, c_px, c_py}, 32'd0);
      chk("rst_tick_fs", {30'd0, c_tk, c_fs}, 32'd0);
      chk("rst_b_sync", {30'd0, b_hs, b_vs}, 32'd0);

      repeat (3) step(1'b1);
      chk("pre_first_fs", {31'd0, c_fs}, 32'd0);
      step(1'b1);
      chk("first_fs", {31'd0, c_fs}, 32'd1);
      chk("first_tick", {31'd0, c_tk}, 32'd1);
      chk("first_vis", {30'd0, c_hv, c_vv}, 32'd3);
      chk("first_px", {22'd0, c_px}, 32'd0);

      repeat (3000) step(1'b1);

      step(1'b0);
      chk("midrst_a", {6'd0, a_hs, a_vs, a_hv, a_vv, a_px, a_py, a_tk, a_fs}, {6'd0, 2'b11, 24'd0});
      repeat (3) step(1'b1);
      chk("midrst_pre_fs", {31'd0, a_fs}, 32'd0);
      step(1'b1);
      chk("midrst_fs", {31'd0, a_fs}, 32'd1);

      repeat (3500) step(1'b1);

      repeat (2) step(1'b0);
      repeat (7000) step(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
